// File: rtl/cgra_array_cfg.sv
// Serial (JTAG-style) configuration loader for a ROWS x COLS CGRA tile array:
// bits shift into a shadow chain and are committed to the live config only after an exact-length session.
module cgra_array_cfg #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int CFG_WIDTH = 16,
    localparam int NUM_TILES = ROWS * COLS,
    localparam int TOTAL     = NUM_TILES * CFG_WIDTH,
    localparam int CW        = $clog2(TOTAL + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             program_mode,
    input  logic             jtag_data_in,
    output logic             jtag_data_out,
    output logic [TOTAL-1:0] cfg_active,
    output logic             cfg_valid,
    output logic             cfg_commit,
    output logic             cfg_error,
    output logic [CW-1:0]    bit_count,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TOTAL + 1);

    state_t            state_q, state_d;
    logic [TOTAL-1:0]  chain_q, chain_d;
    logic [TOTAL-1:0]  active_q, active_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              shift_en;
    logic [TOTAL-1:0]  chain_shifted;
    logic [TOTAL-1:0]  chain_remap;

    generate
        if (TOTAL > 1) begin : g_shift_wide
            assign chain_shifted = {chain_q[TOTAL-2:0], jtag_data_in};
        end else begin : g_shift_one
            assign chain_shifted = jtag_data_in;
        end
    endgenerate

    // Column-serpentine walk: even columns run top-down, odd columns bottom-up.
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                localparam int K = c * ROWS + (((c % 2) == 0) ? r : (ROWS - 1 - r));
                assign chain_remap[(r*COLS+c)*CFG_WIDTH +: CFG_WIDTH] =
                    chain_q[K*CFG_WIDTH +: CFG_WIDTH];
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        error_d  = error_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (program_mode) begin
                    shift_en = 1'b1;
                    cnt_d    = CW'(1);
                    error_d  = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (program_mode) begin
                    shift_en = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q == CNT_FULL) begin
                    state_d = COMMIT;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                // A bit offered during this cycle is intentionally dropped.
                active_d = chain_remap;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        chain_d = shift_en ? chain_shifted : chain_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            chain_q  <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            chain_q  <= chain_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign jtag_data_out = chain_q[TOTAL-1];
    assign cfg_active    = active_q;
    assign cfg_valid     = valid_q;
    assign cfg_commit    = (state_q == COMMIT);
    assign cfg_error     = error_q;
    assign bit_count     = cnt_q;
    assign dbg_state_o   = state_q;

endmodule
